// File: rtl/request_conditioner.sv
// Front-end conditioner for the intersection controller: synchronises and debounces field
// inputs, latches pedestrian requests and arbitrates emergency pre-emption.
module request_conditioner #(
  parameter int unsigned N_LIGHTS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LIGHTS-1:0] btn_ped,
  input  logic [N_LIGHTS-1:0] btn_emerg,
  input  logic                attention_sw,
  input  logic [N_LIGHTS-1:0] lgreen,
  output logic                attention,
  output logic                preset,
  output logic [N_LIGHTS-1:0] preset_adds,
  output logic [N_LIGHTS-1:0] force_reds,
  output logic [N_LIGHTS-1:0] preferentials
);

  localparam int unsigned NDb   = 2 * N_LIGHTS + 1;
  localparam int unsigned NSync = 3 * N_LIGHTS + 1;

  typedef enum logic [1:0] {StIdle, StGrant, StClear} state_e;

  logic [NSync-1:0]          sync1_q, sync2_q;
  logic [NDb-1:0]            db_stable_q, db_stable_d;
  logic [NDb-1:0][7:0]       db_cnt_q, db_cnt_d;
  logic [N_LIGHTS-1:0]       ped_prev_q;
  logic [N_LIGHTS-1:0]       preset_adds_q, preset_adds_d;
  logic                      preset_q, preset_d;
  logic                      attention_q;
  logic [N_LIGHTS-1:0]       force_reds_q, force_reds_d;
  logic [N_LIGHTS-1:0]       pref_q, pref_d;
  state_e                    state_q, state_d;
  logic [1:0]                grant_q, grant_d;
  logic [7:0]                clr_q, clr_d;

  logic [NDb-1:0]            db_sample;
  logic [N_LIGHTS-1:0]       lgreen_s;
  logic [N_LIGHTS-1:0]       ped_db, emerg_db, ped_rise;
  logic                      att_db;

  // Bit layout of the synchroniser: {lgreen, attention_sw, btn_emerg, btn_ped}
  assign db_sample = sync2_q[NDb-1:0];
  assign lgreen_s  = sync2_q[NSync-1 -: N_LIGHTS];
  assign ped_db    = db_stable_q[N_LIGHTS-1:0];
  assign emerg_db  = db_stable_q[2*N_LIGHTS-1:N_LIGHTS];
  assign att_db    = db_stable_q[NDb-1];
  assign ped_rise  = ped_db & ~ped_prev_q;

  always_comb begin
    db_stable_d = db_stable_q;
    db_cnt_d    = '0;
    for (int i = 0; i < int'(NDb); i++) begin
      if (db_sample[i] != db_stable_q[i]) begin
        if (db_cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
          db_stable_d[i] = db_sample[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Green feedback clears the latch and wins over a simultaneous press
  always_comb begin
    preset_adds_d = (preset_adds_q | ped_rise) & ~lgreen_s;
    if (att_db) begin
      preset_adds_d = '0;
    end
    preset_d = |preset_adds_d;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    clr_d   = clr_q;
    unique case (state_q)
      StIdle: begin
        if (|emerg_db) begin
          for (int i = int'(N_LIGHTS) - 1; i >= 0; i--) begin
            if (emerg_db[i]) begin
              grant_d = 2'(i);
            end
          end
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!emerg_db[grant_q]) begin
          clr_d   = 8'(CLEAR_CYCLES);
          state_d = StClear;
        end
      end
      StClear: begin
        if (clr_q <= 8'd1) begin
          clr_d   = 8'd0;
          state_d = StIdle;
        end else begin
          clr_d = clr_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        clr_d   = 8'd0;
      end
    endcase
    if (att_db) begin
      state_d = StIdle;
      clr_d   = 8'd0;
    end
  end

  // Outputs decoded from the next state so they are registered alongside it
  always_comb begin
    pref_d       = '0;
    force_reds_d = '0;
    unique case (state_d)
      StGrant: begin
        pref_d       = N_LIGHTS'(1) << grant_d;
        force_reds_d = ~(N_LIGHTS'(1) << grant_d);
      end
      StClear: force_reds_d = '1;
      default: begin
        pref_d       = '0;
        force_reds_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_stable_q   <= '0;
      db_cnt_q      <= '0;
      ped_prev_q    <= '0;
      preset_adds_q <= '0;
      preset_q      <= 1'b0;
      attention_q   <= 1'b0;
      force_reds_q  <= '0;
      pref_q        <= '0;
      state_q       <= StIdle;
      grant_q       <= 2'd0;
      clr_q         <= 8'd0;
    end else begin
      sync1_q       <= {lgreen, attention_sw, btn_emerg, btn_ped};
      sync2_q       <= sync1_q;
      db_stable_q   <= db_stable_d;
      db_cnt_q      <= db_cnt_d;
      ped_prev_q    <= ped_db;
      preset_adds_q <= preset_adds_d;
      preset_q      <= preset_d;
      attention_q   <= att_db;
      force_reds_q  <= force_reds_d;
      pref_q        <= pref_d;
      state_q       <= state_d;
      grant_q       <= grant_d;
      clr_q         <= clr_d;
    end
  end

  assign attention     = attention_q;
  assign preset        = preset_q;
  assign preset_adds   = preset_adds_q;
  assign force_reds    = force_reds_q;
  assign preferentials = pref_q;

endmodule

// File: tb/tb_request_conditioner.sv
// Directed walk through the conditioner's behaviours, then randomized stimulus checked
// every cycle against a rule-level reference model.
module tb_request_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned CLR = 8;
  localparam int          HIST = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_ped, btn_emerg, lgreen;
  logic       attention_sw;
  logic       attention, preset;
  logic [3:0] preset_adds, force_reds, preferentials;
  logic [13:0] outs;

  int checks   = 0;
  int failures = 0;

  request_conditioner #(
    .N_LIGHTS       (4),
    .DEBOUNCE_CYCLES(DEB),
    .CLEAR_CYCLES   (CLR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_ped      (btn_ped),
    .btn_emerg    (btn_emerg),
    .attention_sw (attention_sw),
    .lgreen       (lgreen),
    .attention    (attention),
    .preset       (preset),
    .preset_adds  (preset_adds),
    .force_reds   (force_reds),
    .preferentials(preferentials)
  );

  always #5 clk = ~clk;

  assign outs = {attention, preset, preset_adds, force_reds, preferentials};

  // Reference model state
  bit          model_on = 1'b0;
  logic [12:0] rawh [HIST];
  logic [8:0]  samp [HIST];
  int          k;
  logic [8:0]  m_db, m_db_prev;
  logic [3:0]  m_pa;
  int          m_granted, m_clear_left;
  logic        m_att;
  int          m_last_flip [9];

  task automatic model_reset();
    k = 0;
    m_db = '0;
    m_db_prev = '0;
    m_pa = '0;
    m_granted = -1;
    m_clear_left = 0;
    m_att = 1'b0;
    for (int b = 0; b < 9; b++) m_last_flip[b] = -1000;
  endtask

  // One clock edge of the model; raw inputs reach the debouncers two edges late
  task automatic model_update();
    logic [12:0] s;
    logic [3:0]  rise, e, lg;
    logic        a;
    bit          all_diff;
    rawh[k] = {lgreen, attention_sw, btn_emerg, btn_ped};
    s = (k >= 2) ? rawh[k-2] : 13'h0;
    samp[k] = s[8:0];
    lg = s[12:9];
    rise = m_db[3:0] & ~m_db_prev[3:0];
    e = m_db[7:4];
    a = m_db[8];
    m_pa = a ? 4'h0 : ((m_pa | rise) & ~lg);
    if (a) begin
      m_granted = -1;
      m_clear_left = 0;
    end else if (m_granted >= 0) begin
      if (!e[m_granted]) begin
        m_granted = -1;
        m_clear_left = CLR;
      end
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else begin
      for (int i = 3; i >= 0; i--) if (e[i]) m_granted = i;
    end
    m_att = a;
    m_db_prev = m_db;
    // A level is accepted once DEB consecutive samples since the last change all differ
    for (int b = 0; b < 9; b++) begin
      all_diff = (k - m_last_flip[b] >= int'(DEB));
      for (int j = 0; j < int'(DEB); j++) begin
        if (k - j < 0) all_diff = 1'b0;
        else if (samp[k-j][b] == m_db[b]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_db[b] = ~m_db[b];
        m_last_flip[b] = k;
      end
    end
    k++;
  endtask

  function automatic logic [13:0] model_outs();
    logic [3:0] pref, fr;
    pref = (m_granted >= 0) ? (4'b0001 << m_granted) : 4'h0;
    fr   = (m_granted >= 0) ? ~pref : ((m_clear_left > 0) ? 4'hF : 4'h0);
    return {m_att, |m_pa, m_pa, fr, pref};
  endfunction

  task automatic step();
    @(posedge clk);
    if (model_on && k < HIST) model_update();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int len;

    // Reset with every input active
    rst = 1'b0;
    btn_ped = 4'hF; btn_emerg = 4'hF; attention_sw = 1'b1; lgreen = 4'hF;
    step(); step();
    chk("reset_hold", 16'(outs), 16'h0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("reset_release_quiet", 16'(outs), 16'h0);
    end
    step();
    chk("reset_attention_up", 16'(outs), 16'h2000);
    step(); step();
    chk("reset_attention_masks", 16'(outs), 16'h2000);
    btn_ped = 4'h0; btn_emerg = 4'h0; attention_sw = 1'b0; lgreen = 4'h0;
    repeat (10) step();
    chk("idle_after_release", 16'(outs), 16'h0);

    // Debounce and green clear
    btn_ped = 4'b0100;
    repeat (3) step();
    btn_ped = 4'b0000;
    repeat (10) step();
    chk("glitch_dropped", 16'({preset, preset_adds}), 16'h0);
    btn_ped = 4'b0100;
    repeat (6) step();
    chk("ped_latency_early", 16'({preset, preset_adds}), 16'h0);
    step();
    chk("ped_latency", 16'({preset, preset_adds}), 16'b10100);
    btn_ped = 4'b0000; lgreen = 4'b0100;
    step(); step();
    chk("green_clear_early", 16'({preset, preset_adds}), 16'b10100);
    step();
    chk("green_clear", 16'({preset, preset_adds}), 16'h0);
    lgreen = 4'b0000;
    repeat (10) step();

    // Press during green is dropped
    lgreen = 4'b0010;
    repeat (3) step();
    btn_ped = 4'b0010;
    repeat (10) step();
    chk("ped_during_green", 16'({preset, preset_adds}), 16'h0);
    btn_ped = 4'b0000; lgreen = 4'b0000;
    repeat (10) step();
    chk("ped_green_dropped", 16'({preset, preset_adds}), 16'h0);
    btn_ped = 4'b0010;
    repeat (7) step();
    chk("ped_after_green", 16'({preset, preset_adds}), 16'b10010);
    btn_ped = 4'b0000; lgreen = 4'b0010;
    repeat (4) step();
    lgreen = 4'b0000;
    repeat (8) step();
    chk("ped_cleared", 16'({preset, preset_adds}), 16'h0);

    // Emergency arbitration and clearance
    btn_emerg = 4'b1010; btn_ped = 4'b0001;
    repeat (6) step();
    chk("emerg_latency_early", 16'({force_reds, preferentials}), 16'h0);
    step();
    chk("emerg_grant_1", 16'({force_reds, preferentials}), 16'b1101_0010);
    chk("ped_during_emerg", 16'({preset, preset_adds}), 16'b10001);
    btn_emerg = 4'b1000; btn_ped = 4'b0000;
    repeat (6) step();
    chk("grant_hold", 16'({force_reds, preferentials}), 16'b1101_0010);
    for (int i = 0; i < int'(CLR); i++) begin
      step();
      chk("clear_hold", 16'({force_reds, preferentials}), 16'hF0);
    end
    step();
    chk("clear_exit_idle", 16'({force_reds, preferentials}), 16'h0);
    step();
    chk("emerg_grant_3", 16'({force_reds, preferentials}), 16'b0111_1000);

    // Attention override
    attention_sw = 1'b1;
    repeat (6) step();
    chk("att_latency_early", 16'({attention, force_reds, preferentials}), 16'b0_0111_1000);
    step();
    chk("att_override", 16'(outs), 16'h2000);
    btn_emerg = 4'b0001;
    repeat (10) step();
    chk("att_hold", 16'(outs), 16'h2000);
    attention_sw = 1'b0;
    repeat (6) step();
    chk("att_release_early", 16'(outs), 16'h2000);
    step();
    chk("emerg_grant_0", 16'(outs), 16'b00_0000_1110_0001);

    // Reset in the middle of clearance
    btn_emerg = 4'b0000;
    repeat (7) step();
    chk("clear_c1", 16'({force_reds, preferentials}), 16'hF0);
    repeat (2) step();
    chk("clear_c3", 16'({force_reds, preferentials}), 16'hF0);
    rst = 1'b0;
    #1;
    chk("rst_async", 16'(outs), 16'h0);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    chk("rst_no_clear_hold", 16'(outs), 16'h0);

    // Randomized stimulus against the model
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    model_on = 1'b1;
    for (int seg = 0; seg < 90; seg++) begin
      btn_ped      = 4'($urandom);
      btn_emerg    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      attention_sw = ($urandom_range(0, 9) == 0);
      lgreen       = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        step();
        chk("random", 16'(outs), 16'(model_outs()));
      end
    end
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
